// File: rtl/feature_packer_if.sv
// Upstream beat bus for feature_packer: one LANES-word beat per accepted cycle.
// Optional FEATURE_PACKER_LAST_CHECK_EN adds the in_last frame marker.
interface feature_packer_if #(
    parameter int unsigned LANES = 12,
    parameter int unsigned DLEN  = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DLEN-1:0]   in_data;
`ifdef FEATURE_PACKER_LAST_CHECK_EN
    logic                    in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
`else
    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
`endif
endinterface

// File: rtl/feature_packer.sv
// feature_packer: assembles BEATS beats of LANES words into one wide vector,
// presents it with load held high until the consumer acknowledges with valid,
// then spends one RELEASE cycle with load low before refilling.
// Optional macro FEATURE_PACKER_LAST_CHECK_EN adds in_last framing check and a
// sticky err output.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module feature_packer #(
    parameter int unsigned LANES = 12,
    parameter int unsigned BEATS = 32,
    parameter int unsigned DLEN  = `DATA_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    feature_packer_if.slave               up,
    output logic                          load,
    output logic [BEATS*LANES*DLEN-1:0]   d,
    input  logic                          valid,
    output logic [7:0]                    frame_cnt
`ifdef FEATURE_PACKER_LAST_CHECK_EN
    ,
    output logic                          err
`endif
);

    localparam int unsigned BEAT_W = LANES * DLEN;
    localparam int unsigned IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_FILL    = 2'd0,
        S_HOLD    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   beat_idx_q, beat_idx_d;
    logic               accept_c;
    logic               last_beat_c;
    logic               cnt_inc_c;
`ifdef FEATURE_PACKER_LAST_CHECK_EN
    logic               last_err_c;
`endif

    // Next-state, beat index and event strobes.
    always_comb begin
        state_d     = state_q;
        beat_idx_d  = beat_idx_q;
        accept_c    = up.in_valid && up.in_ready && (state_q == S_FILL);
        last_beat_c = (beat_idx_q == IDX_W'(BEATS - 1));
        cnt_inc_c   = 1'b0;
`ifdef FEATURE_PACKER_LAST_CHECK_EN
        last_err_c  = 1'b0;
`endif
        case (state_q)
            S_FILL: begin
                if (accept_c) begin
`ifdef FEATURE_PACKER_LAST_CHECK_EN
                    // A misplaced or missing in_last discards the partial frame.
                    if (up.in_last != last_beat_c) begin
                        last_err_c = 1'b1;
                        beat_idx_d = '0;
                    end else
`endif
                    if (last_beat_c) begin
                        beat_idx_d = '0;
                        state_d    = S_HOLD;
                    end else begin
                        beat_idx_d = beat_idx_q + IDX_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (valid) begin
                    state_d   = S_RELEASE;
                    cnt_inc_c = 1'b1;
                end
            end
            S_RELEASE: begin
                // valid may still be high from the consumer; ignore it here.
                state_d = S_FILL;
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // State, registered handshake outputs, frame counter and vector storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            beat_idx_q  <= '0;
            load        <= 1'b0;
            up.in_ready <= 1'b1;
            frame_cnt   <= 8'd0;
            d           <= '0;
`ifdef FEATURE_PACKER_LAST_CHECK_EN
            err         <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_idx_q  <= beat_idx_d;
            load        <= (state_d == S_HOLD);
            up.in_ready <= (state_d == S_FILL);
            if (cnt_inc_c) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (accept_c) begin
                d[int'(beat_idx_q) * int'(BEAT_W) +: BEAT_W] <= up.in_data;
            end
`ifdef FEATURE_PACKER_LAST_CHECK_EN
            if (last_err_c) begin
                err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_feature_packer.sv
// Directed self-checking bench for feature_packer (default LANES=12, BEATS=32).
// Build with FEATURE_PACKER_LAST_CHECK_EN defined to also exercise in_last/err.
`timescale 1ns/1ps

module tb_feature_packer;

    localparam int unsigned LANES  = 12;
    localparam int unsigned BEATS  = 32;
    localparam int unsigned DLEN   = 16;
    localparam int unsigned BEAT_W = LANES * DLEN;
    localparam int unsigned VEC_W  = BEATS * BEAT_W;

    logic               clk;
    logic               rst;
    logic               load;
    logic [VEC_W-1:0]   d;
    logic               valid;
    logic [7:0]         frame_cnt;
`ifdef FEATURE_PACKER_LAST_CHECK_EN
    logic               err;
`endif

    int                 n_checks;
    int                 n_errors;
    int                 cycles;
    logic [VEC_W-1:0]   d_saved;

    feature_packer_if #(.LANES(LANES), .DLEN(DLEN)) u_if ();

    feature_packer #(
        .LANES (LANES),
        .BEATS (BEATS),
        .DLEN  (DLEN)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .up        (u_if.slave),
        .load      (load),
        .d         (d),
        .valid     (valid),
        .frame_cnt (frame_cnt)
`ifdef FEATURE_PACKER_LAST_CHECK_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it on mismatch.
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BEAT_W-1:0] beat_pat(input int seed, input int k);
        logic [BEAT_W-1:0] w;
        for (int i = 0; i < int'(LANES); i++) begin
            w[i*DLEN +: DLEN] = DLEN'((seed << 8) | k);
        end
        return w;
    endfunction

    // Push n beats; optional idle cycle between beats; in_last on beat last_at.
    task automatic send_beats(input int seed, input int n, input bit gaps, input int last_at);
        cycles = 0;
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) begin
                u_if.in_valid = 1'b0;
                step();
                cycles++;
            end
            u_if.in_valid = 1'b1;
            u_if.in_data  = beat_pat(seed, k);
`ifdef FEATURE_PACKER_LAST_CHECK_EN
            u_if.in_last  = (k == last_at);
`endif
            step();
            cycles++;
            if (k == n - 2) check("load_before_last", 256'(load), 256'(0));
        end
        u_if.in_valid = 1'b0;
`ifdef FEATURE_PACKER_LAST_CHECK_EN
        u_if.in_last  = 1'b0;
`endif
        if (last_at < 0) cycles = 0;
    endtask

    task automatic check_frame(input int seed);
        for (int k = 0; k < int'(BEATS); k++) begin
            check($sformatf("d_slice%0d", k), 256'(d[k*BEAT_W +: BEAT_W]), 256'(beat_pat(seed, k)));
        end
    endtask

    // One-cycle acknowledge, then confirm RELEASE and return to FILL.
    task automatic ack(input int exp_cnt);
        valid = 1'b1;
        step();
        check("ack_load", 256'(load), 256'(0));
        check("ack_ready_release", 256'(u_if.in_ready), 256'(0));
        check("ack_frame_cnt", 256'(frame_cnt), 256'(exp_cnt));
        valid = 1'b0;
        step();
        check("ack_ready_fill", 256'(u_if.in_ready), 256'(1));
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        valid         = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.in_data  = '0;
`ifdef FEATURE_PACKER_LAST_CHECK_EN
        u_if.in_last  = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        check("rst_ready", 256'(u_if.in_ready), 256'(1));
        check("rst_load", 256'(load), 256'(0));
        check("rst_frame_cnt", 256'(frame_cnt), 256'(0));
        check("rst_d_zero", 256'(|d), 256'(0));

        // Back-to-back frame: load one cycle after beat 31.
        send_beats(1, BEATS, 1'b0, BEATS - 1);
        check("f1_load", 256'(load), 256'(1));
        check("f1_cycles", 256'(cycles), 256'(32));
        check("f1_ready_hold", 256'(u_if.in_ready), 256'(0));
        check_frame(1);

        // Long HOLD with upstream pushing: nothing accepted, d stable.
        d_saved = d;
        for (int c = 0; c < 100; c++) begin
            u_if.in_valid = 1'b1;
            u_if.in_data  = beat_pat(9, c % 32);
            step();
            if (c % 25 == 24) begin
                check("hold_load", 256'(load), 256'(1));
                check("hold_ready", 256'(u_if.in_ready), 256'(0));
            end
        end
        u_if.in_valid = 1'b0;
        check("hold_d_stable", 256'(d == d_saved), 256'(1));
        check("hold_cnt", 256'(frame_cnt), 256'(0));

        // Acknowledge with valid held through RELEASE and into FILL.
        valid = 1'b1;
        step();
        check("rel_load", 256'(load), 256'(0));
        check("rel_ready", 256'(u_if.in_ready), 256'(0));
        check("rel_cnt", 256'(frame_cnt), 256'(1));
        step();
        check("fill_ready", 256'(u_if.in_ready), 256'(1));
        check("fill_cnt", 256'(frame_cnt), 256'(1));
        for (int c = 0; c < 3; c++) begin
            step();
            check("stale_valid_cnt", 256'(frame_cnt), 256'(1));
            check("stale_valid_load", 256'(load), 256'(0));
            check("stale_valid_ready", 256'(u_if.in_ready), 256'(1));
        end
        valid = 1'b0;

        // Gapped frame: 32 accepted beats span 63 cycles.
        send_beats(2, BEATS, 1'b1, BEATS - 1);
        check("f2_load", 256'(load), 256'(1));
        check("f2_cycles", 256'(cycles), 256'(63));
        check_frame(2);
        ack(2);

        // Reset mid-FILL after beat 17 discards the partial frame.
        send_beats(7, 18, 1'b0, BEATS - 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_cnt", 256'(frame_cnt), 256'(0));
        check("mid_rst_d_zero", 256'(|d), 256'(0));
        check("mid_rst_ready", 256'(u_if.in_ready), 256'(1));
        check("mid_rst_load", 256'(load), 256'(0));
        send_beats(3, BEATS, 1'b0, BEATS - 1);
        check("f3_load", 256'(load), 256'(1));
        check_frame(3);
        ack(1);

`ifdef FEATURE_PACKER_LAST_CHECK_EN
        // Early in_last on beat 10 aborts the frame and sets sticky err.
        check("err_reset", 256'(err), 256'(0));
        send_beats(5, 11, 1'b0, 10);
        check("early_last_err", 256'(err), 256'(1));
        check("early_last_load", 256'(load), 256'(0));
        check("early_last_ready", 256'(u_if.in_ready), 256'(1));
        step();
        check("early_last_noload", 256'(load), 256'(0));
        send_beats(6, BEATS, 1'b0, BEATS - 1);
        check("f4_load", 256'(load), 256'(1));
        check("f4_err_sticky", 256'(err), 256'(1));
        check_frame(6);
        ack(2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
